insere_linha: RTL and testbench



---
 rtl/insere_linha_pkg.sv | 54 +++++
 rtl/insere_linha_envelhece.sv | 58 +++++
 rtl/insere_linha.sv | 171 +++++++++++++++++
 tb/tb_insere_linha.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/insere_linha_pkg.sv
// ---------------------------------------------------------------------------
// insere_linha_pkg
// Shared definitions for the time-sliced Bloom line memory insert engine.
// Holds the line geometry, the field-slice positions (also used by the
// line-aging readers), the insert FSM encoding and a small line-packing
// helper.
// ---------------------------------------------------------------------------
package insere_linha_pkg;

    // Line geometry
    localparam int DATA_WIDTH     = 72;
    localparam int NUM_BUCKETS    = 12;
    localparam int BUCKET_SZ      = 4;
    localparam int BITS_SHIFT     = 4;
    localparam int BLOOM_INIT_POS = 16;
    localparam int ADDR_WIDTH     = 10;

    // Derived widths
    localparam int LOOP_W  = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int BIT_W   = $clog2(BUCKET_SZ);
    localparam int BLOOM_W = DATA_WIDTH - BLOOM_INIT_POS;
    localparam int FB      = BLOOM_W / BUCKET_SZ;
    localparam int AGE_W   = LOOP_W + BITS_SHIFT + 2;
    localparam int SH_W    = $clog2(BLOOM_W);

    // Field-slice positions inside a stored line
    localparam int BUCKET_MSB = BLOOM_INIT_POS - 1;
    localparam int BUCKET_LSB = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int LOOP_MSB   = BUCKET_LSB - 1;
    localparam int LOOP_LSB   = 0;
    localparam int BLOOM_MSB  = DATA_WIDTH - 1;
    localparam int BLOOM_LSB  = BLOOM_INIT_POS;

    // Position of the newest bucket's LSB inside the bloom field
    localparam int NEWEST_LSB = BLOOM_W - BUCKET_SZ;

    // Insert FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_UPDATE = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Assemble a line from its bloom field and time stamp.
    function automatic logic [DATA_WIDTH-1:0] make_line(
        input logic [BLOOM_W-1:0]    bloom,
        input logic [BITS_SHIFT-1:0] bucket,
        input logic [LOOP_W-1:0]     loop
    );
        return {bloom, bucket, loop};
    endfunction

endpackage

// File: rtl/insere_linha_envelhece.sv
// ---------------------------------------------------------------------------
// linha_envelhece
// Combinational aging shifter. Given a stored line and the current time
// stamp, returns the line's bloom field advanced to that stamp: buckets older
// than the window fall off the LSB end and the vacated newest buckets are
// zero. A line whose age is negative, beyond the window, or whose stored
// bucket index is out of range yields an empty field.
//
// Ports
//   line          in   DATA_WIDTH  stored line (bloom | bucket | loop)
//   stamp_bucket  in   BITS_SHIFT  time slot to age to
//   stamp_loop    in   LOOP_W      loop to age to
//   aged          out  BLOOM_W     aged bloom field
// ---------------------------------------------------------------------------
module linha_envelhece
    import insere_linha_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] line,
    input  logic [BITS_SHIFT-1:0] stamp_bucket,
    input  logic [LOOP_W-1:0]     stamp_loop,
    output logic [BLOOM_W-1:0]    aged
);

    logic [BLOOM_W-1:0]       bloom;
    logic [BITS_SHIFT-1:0]    line_bucket;
    logic [LOOP_W-1:0]        line_loop;
    logic [LOOP_W-1:0]        dl;
    logic signed [AGE_W-1:0]  age;
    logic [SH_W-1:0]          sh;
    logic                     keep;

    assign bloom       = line[BLOOM_MSB:BLOOM_LSB];
    assign line_bucket = line[BUCKET_MSB:BUCKET_LSB];
    assign line_loop   = line[LOOP_MSB:LOOP_LSB];

    always_comb begin
        // Loop difference wraps naturally in LOOP_W bits.
        dl  = stamp_loop - line_loop;
        // Widened so that dl*NUM_BUCKETS plus a bucket delta never overflows
        // and a stamp behind the line reads as negative.
        age = signed'(AGE_W'(dl) * AGE_W'(NUM_BUCKETS)
                      + AGE_W'(stamp_bucket)
                      - AGE_W'(line_bucket));

        keep = (age >= signed'(AGE_W'(0)))
            && (age <  signed'(AGE_W'(FB)))
            && (line_bucket < BITS_SHIFT'(NUM_BUCKETS));

        // Only evaluated meaningfully when keep is set (age < FB).
        sh = SH_W'($unsigned(age)) * SH_W'(BUCKET_SZ);

        aged = '0;
        if (keep) begin
            aged = bloom >> sh;
        end
    end

endmodule

// File: rtl/insere_linha.sv
// ---------------------------------------------------------------------------
// insere_linha
// Insert engine for the time-sliced Bloom line memory. Each accepted
// (address, bit) request performs one read-modify-write: the line is read,
// aged to the stamp taken at accept time, the requested bit is set in the
// newest bucket, and the line is written back stamped with that time.
// The engine also owns the time base (cur_bucket / cur_loop).
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | ready for a request; latches addr, bit and time stamp
//   ST_READ    | rd_req held until rd_ack; captures the line
//   ST_UPDATE  | one cycle; registers the aged + updated line
//   ST_WRITE   | wr_req held until wr_ack; done pulses with the ack
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   tick                     advance time slot by one
//   in_valid/in_addr/in_bit  insert request; in_ready high while idle
//   rd_req/rd_addr           line read request, held until rd_ack
//   rd_ack/rd_data           read completion with line data
//   wr_req/wr_addr/wr_data   line write request, held until wr_ack
//   wr_ack                   write accepted
//   done                     one-cycle pulse with the accepted write
//   cur_bucket/cur_loop      current time base
// ---------------------------------------------------------------------------
module insere_linha
    import insere_linha_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BIT_W-1:0]      in_bit,
    output logic                  in_ready,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_ack,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ack,
    output logic                  done,
    output logic [BITS_SHIFT-1:0] cur_bucket,
    output logic [LOOP_W-1:0]     cur_loop
);

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BIT_W-1:0]      bit_q;
    logic [BITS_SHIFT-1:0] stamp_bucket_q;
    logic [LOOP_W-1:0]     stamp_loop_q;
    logic [DATA_WIDTH-1:0] line_q;
    logic [DATA_WIDTH-1:0] wr_data_q;

    logic [BLOOM_W-1:0]    aged;
    logic [BLOOM_W-1:0]    bloom_new;

    // -----------------------------------------------------------------------
    // Time base
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_bucket <= '0;
            cur_loop   <= '0;
        end else if (tick) begin
            if (cur_bucket == BITS_SHIFT'(NUM_BUCKETS - 1)) begin
                cur_bucket <= '0;
                cur_loop   <= cur_loop + 1'b1;
            end else begin
                cur_bucket <= cur_bucket + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Aging and update of the captured line
    // -----------------------------------------------------------------------
    linha_envelhece u_envelhece (
        .line         (line_q),
        .stamp_bucket (stamp_bucket_q),
        .stamp_loop   (stamp_loop_q),
        .aged         (aged)
    );

    always_comb begin
        bloom_new = aged | (BLOOM_W'(1) << (NEWEST_LSB + int'(bit_q)));
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            addr_q         <= '0;
            bit_q          <= '0;
            stamp_bucket_q <= '0;
            stamp_loop_q   <= '0;
            line_q         <= '0;
            wr_data_q      <= '0;
        end else begin
            state <= state_nxt;

            // The stamp is the time base as seen before any tick on this edge.
            if (state == ST_IDLE && in_valid) begin
                addr_q         <= in_addr;
                bit_q          <= in_bit;
                stamp_bucket_q <= cur_bucket;
                stamp_loop_q   <= cur_loop;
            end

            if (state == ST_READ && rd_ack) begin
                line_q <= rd_data;
            end

            if (state == ST_UPDATE) begin
                wr_data_q <= make_line(bloom_new, stamp_bucket_q, stamp_loop_q);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        done      = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                rd_req = 1'b1;
                if (rd_ack) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                wr_req = 1'b1;
                if (wr_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_addr = addr_q;
    assign wr_addr = addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_insere_linha.sv
// ---------------------------------------------------------------------------
// tb_insere_linha
// Directed bench for the insert engine: hand-computed line updates, time
// base stepping, stalled handshakes and reset during a write.
// ---------------------------------------------------------------------------
module tb_insere_linha;

    logic        clk;
    logic        reset_n;
    logic        tick;
    logic        in_valid;
    logic [9:0]  in_addr;
    logic [1:0]  in_bit;
    logic        in_ready;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        rd_ack;
    logic [71:0] rd_data;
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [71:0] wr_data;
    logic        wr_ack;
    logic        done;
    logic [3:0]  cur_bucket;
    logic [11:0] cur_loop;

    int total;
    int bad;

    insere_linha dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .done       (done),
        .cur_bucket (cur_bucket),
        .cur_loop   (cur_loop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic advance(input int n);
        tick = 1'b1;
        repeat (n) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic check_time(input string tag, input logic [3:0] b, input logic [11:0] l);
        check({tag, ".bucket"}, 72'(cur_bucket), 72'(b));
        check({tag, ".loop"},   72'(cur_loop),   72'(l));
    endtask

    // One full insert; entered and left just after a falling edge.
    task automatic insert(
        input string       tag,
        input logic [9:0]  a,
        input logic [1:0]  b,
        input logic [71:0] line,
        input int          rd_wait,
        input int          wr_wait,
        input logic        tick_acc,
        input logic        tick_rd,
        input logic        poke_busy,
        input logic [71:0] exp_wdata
    );
        in_valid = 1'b1;
        in_addr  = a;
        in_bit   = b;
        tick     = tick_acc;
        #1;
        check({tag, ".ready_idle"}, 72'(in_ready), 72'd1);
        @(negedge clk);
        in_valid = 1'b0;
        tick     = tick_rd;
        check({tag, ".rd_req"},  72'(rd_req),  72'd1);
        check({tag, ".rd_addr"}, 72'(rd_addr), 72'(a));
        check({tag, ".busy"},    72'(in_ready), 72'd0);
        for (int i = 0; i < rd_wait; i++) begin
            if (poke_busy) begin
                in_valid = 1'b1;
                in_addr  = ~a;
            end
            @(negedge clk);
            tick = 1'b0;
            check({tag, ".rd_hold"},  72'(rd_req),  72'd1);
            check({tag, ".rd_addr_hold"}, 72'(rd_addr), 72'(a));
            check({tag, ".busy_stall"}, 72'(in_ready), 72'd0);
        end
        in_valid = 1'b0;
        in_addr  = a;
        rd_ack   = 1'b1;
        rd_data  = line;
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = '0;
        tick    = 1'b0;
        check({tag, ".upd_no_rd"}, 72'(rd_req), 72'd0);
        check({tag, ".upd_no_wr"}, 72'(wr_req), 72'd0);
        @(negedge clk);
        check({tag, ".wr_req"},  72'(wr_req),  72'd1);
        check({tag, ".wr_addr"}, 72'(wr_addr), 72'(a));
        check({tag, ".wr_data"}, wr_data, exp_wdata);
        for (int i = 0; i < wr_wait; i++) begin
            check({tag, ".no_done_early"}, 72'(done), 72'd0);
            @(negedge clk);
            check({tag, ".wr_hold"}, 72'(wr_req), 72'd1);
            check({tag, ".wr_data_hold"}, wr_data, exp_wdata);
        end
        wr_ack = 1'b1;
        #1;
        check({tag, ".done"}, 72'(done), 72'd1);
        @(negedge clk);
        wr_ack = 1'b0;
        check({tag, ".done_once"},   72'(done),     72'd0);
        check({tag, ".ready_after"}, 72'(in_ready), 72'd1);
        check({tag, ".wr_dropped"},  72'(wr_req),   72'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset_n  = 1'b0;
        tick     = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_bit   = '0;
        rd_ack   = 1'b0;
        rd_data  = '0;
        wr_ack   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst.in_ready", 72'(in_ready), 72'd1);
        check("rst.rd_req",   72'(rd_req),   72'd0);
        check("rst.wr_req",   72'(wr_req),   72'd0);
        check("rst.done",     72'(done),     72'd0);
        check("rst.wr_data",  wr_data,       72'd0);
        check_time("rst", 4'd0, 12'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fresh line at time (0,0)
        insert("fresh", 10'h011, 2'd0, 72'd0, 0, 0, 1'b0, 1'b0, 1'b0,
               {56'h10000000000000, 4'd0, 12'd0});

        // Move to (0,5); line (0,3) is 24 slots old -> cleared
        advance(60);
        check_time("t60", 4'd0, 12'd5);
        insert("age24", 10'h2A5, 2'd2, {56'hFFFFFFFFFFFFFF, 4'd0, 12'd3}, 0, 0, 1'b0, 1'b0, 1'b0,
               {56'h40000000000000, 4'd0, 12'd5});

        // (5,5): line (3,5) age 2
        advance(5);
        check_time("t65", 4'd5, 12'd5);
        insert("age2", 10'h003, 2'd0, {56'hF0000000000000, 4'd3, 12'd5}, 0, 0, 1'b0, 1'b0, 1'b0,
               {56'h10F00000000000, 4'd5, 12'd5});

        // (1,8): line (11,7) crosses a loop, age 2
        advance(32);
        check_time("t97", 4'd1, 12'd8);
        insert("loopx", 10'h155, 2'd3, {56'hA0B0C0D0E0F012, 4'd11, 12'd7}, 0, 0, 1'b0, 1'b0, 1'b0,
               {56'h80A0B0C0D0E0F0, 4'd1, 12'd8});

        // Ticks in the accept cycle and in READ leave the stamp at (1,8)
        insert("tick", 10'h0F0, 2'd1, {56'h00000000000001, 4'd1, 12'd8}, 0, 0, 1'b1, 1'b1, 1'b0,
               {56'h20000000000001, 4'd1, 12'd8});
        check_time("tick_after", 4'd3, 12'd8);

        // Stalled handshakes with a second request poked while busy
        insert("stall", 10'h3C3, 2'd0, {56'h0123456789ABCD, 4'd2, 12'd8}, 5, 5, 1'b0, 1'b0, 1'b1,
               {56'h10123456789ABC, 4'd3, 12'd8});
        check("stall.no_second", 72'(rd_req), 72'd0);
        @(negedge clk);
        check("stall.still_idle", 72'(rd_req), 72'd0);

        // Out-of-range stored bucket / negative age -> cleared
        insert("badbkt", 10'h001, 2'd1, {56'hFFFFFFFFFFFFFF, 4'd13, 12'd8}, 0, 0, 1'b0, 1'b0, 1'b0,
               {56'h20000000000000, 4'd3, 12'd8});

        // Reset while WRITE is pending
        in_valid = 1'b1;
        in_addr  = 10'h077;
        in_bit   = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        rd_ack   = 1'b1;
        rd_data  = '0;
        @(negedge clk);
        rd_ack = 1'b0;
        @(negedge clk);
        check("rstw.in_write", 72'(wr_req), 72'd1);
        #2;
        wr_ack  = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rstw.wr_req",   72'(wr_req),   72'd0);
        check("rstw.rd_req",   72'(rd_req),   72'd0);
        check("rstw.in_ready", 72'(in_ready), 72'd1);
        check("rstw.done",     72'(done),     72'd0);
        check_time("rstw", 4'd0, 12'd0);
        @(negedge clk);
        wr_ack  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("rstw.idle_done", 72'(done),     72'd0);
        check("rstw.idle_rdy",  72'(in_ready), 72'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
